// File: rtl/rca_multiword_sequencer_pkg.sv
// Shared definitions for the multi-word ripple-carry sequencer: nibble width and FSM encoding.
package rca_multiword_sequencer_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADD_AB  = 2'd1,
        ADD_CIN = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/rca_multiword_sequencer_rca.sv
// 4-bit ripple-carry adder with no carry-in; purely combinational.
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       c
);

    logic cy;

    // Carry ripples bit by bit through a single scalar to avoid a self-referencing vector.
    always_comb begin
        cy = 1'b0;
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        c = cy;
    end

endmodule

// File: rtl/rca_multiword_sequencer.sv
// Adds two NIBBLES*4-bit operands on one shared 4-bit adder, two passes per nibble, LSB nibble first.
module rca_multiword_sequencer
    import rca_multiword_sequencer_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cin,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
    output logic                        ready,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        carry_out
);

    localparam int unsigned W        = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e                state;
    state_e                next_state;
    logic [W-1:0]          a_reg;
    logic [W-1:0]          b_reg;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic [NIBBLE_W-1:0]   part;
    logic                  c1;
    logic [NIBBLE_W-1:0]   add_a;
    logic [NIBBLE_W-1:0]   add_b;
    logic [NIBBLE_W-1:0]   add_s;
    logic                  add_c;
    logic                  last_c;

    assign last_c = (idx == LAST_IDX);

    ripple_carry_adder u_rca (
        .a (add_a),
        .b (add_b),
        .s (add_s),
        .c (add_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADD_AB;
            ADD_AB:  next_state = ADD_CIN;
            ADD_CIN: next_state = last_c ? DONE : ADD_AB;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Adder operand mux: A+B on the first pass, partial sum + incoming carry on the second
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            ADD_AB: begin
                add_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
                add_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];
            end
            ADD_CIN: begin
                add_a = part;
                add_b = {3'b000, carry};
            end
            default: ;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b1;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            part      <= '0;
            c1        <= 1'b0;
        end else begin
            ready <= (next_state == IDLE);
            done  <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        carry     <= cin;
                        idx       <= '0;
                        sum       <= '0;
                        carry_out <= 1'b0;
                    end
                end
                ADD_AB: begin
                    part <= add_s;
                    c1   <= add_c;
                end
                ADD_CIN: begin
                    // c1 and add_c are mutually exclusive, so OR forms the nibble carry
                    sum[NIBBLE_W*idx +: NIBBLE_W] <= add_s;
                    carry <= c1 | add_c;
                    if (last_c) carry_out <= c1 | add_c;
                    else        idx       <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Directed and random checks of the multi-word ripple-carry sequencer (NIBBLES=4 and NIBBLES=1).
module tb_rca_multiword_sequencer;
    import rca_multiword_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        ready;
    logic        done;
    logic [15:0] sum;
    logic        carry_out;

    logic        s_start = 1'b0;
    logic        s_cin = 1'b0;
    logic [3:0]  s_a = '0;
    logic [3:0]  s_b = '0;
    logic        s_ready;
    logic        s_done;
    logic [3:0]  s_sum;
    logic        s_carry_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic both_seen = 1'b0;

    always #5 clk = ~clk;

    rca_multiword_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cin(cin), .op_a(op_a), .op_b(op_b),
        .ready(ready), .done(done), .sum(sum), .carry_out(carry_out)
    );

    rca_multiword_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .cin(s_cin), .op_a(s_a), .op_b(s_b),
        .ready(s_ready), .done(s_done), .sum(s_sum), .carry_out(s_carry_out)
    );

    // Flags any second pass where both carries would be set
    always @(negedge clk)
        if (!rst && dut.state == ADD_CIN && dut.c1 && dut.add_c) both_seen <= 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [16:0] exp);
        int k;
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        start = 1'b1; op_a = a; op_b = b; cin = ci;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk({tag, "_latency"}, 64'(k), 64'd8);
        chk({tag, "_result"}, 64'({carry_out, sum}), 64'(exp));
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done), 64'd0);
    endtask

    task automatic run_op1(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic ci, input logic [4:0] exp);
        int k;
        s_start = 1'b1; s_a = a; s_b = b; s_cin = ci;
        @(negedge clk);
        s_start = 1'b0;
        k = 0;
        while (s_done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd2);
        chk({tag, "_result"}, 64'({s_carry_out, s_sum}), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        int k;
        int no_done;
        logic [15:0] ra, rb;
        logic        rc;

        // 1. Reset values while rst is high
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry_out", 64'(carry_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 2-4. Directed arithmetic
        run_op("t2_1234_4321", 16'h1234, 16'h4321, 1'b0, 17'h05555);
        run_op("t3_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        run_op("t4_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        chk("t4_c1_and_c", 64'(both_seen), 64'd0);

        // 5. Held start, operands churning while busy, back-to-back accept
        start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0;
        @(negedge clk);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            cin  = 1'($urandom);
            @(negedge clk);
            k++;
        end
        chk("t5_latency", 64'(k), 64'd8);
        chk("t5_latched_result", 64'({carry_out, sum}), 64'h05555);
        op_a = 16'h0102; op_b = 16'h0304; cin = 1'b1;
        @(negedge clk);
        chk("t5_done_width", 64'(done), 64'd0);
        chk("t5_idle_ready", 64'(ready), 64'd1);
        @(negedge clk);
        chk("t5_b2b_accepted", 64'(ready), 64'd0);
        chk("t5_b2b_sum_cleared", 64'({carry_out, sum}), 64'd0);
        start = 1'b0;
        wait_done(k);
        chk("t5_b2b_latency", 64'(k), 64'd8);
        chk("t5_b2b_result", 64'({carry_out, sum}), 64'h00407);
        @(negedge clk);

        // 6. Reset in the third busy cycle aborts without a done pulse
        start = 1'b1; op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_abort_ready", 64'(ready), 64'd1);
        chk("t6_abort_done", 64'(done), 64'd0);
        chk("t6_abort_sum", 64'({carry_out, sum}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) no_done++;
        end
        chk("t6_no_done_pulse", 64'(no_done), 64'd0);
        run_op("t6_after_0001_0001", 16'h0001, 16'h0001, 1'b0, 17'h00002);

        // Random operands against a + b + cin
        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            start = 1'b1; op_a = ra; op_b = rb; cin = rc;
            @(negedge clk);
            start = 1'b0;
            wait_done(k);
            chk("rand_result", 64'({carry_out, sum}), 64'(17'(ra) + 17'(rb) + 17'(rc)));
            @(negedge clk);
        end
        chk("rand_latency_last", 64'(k), 64'd8);
        chk("rand_c1_and_c", 64'(both_seen), 64'd0);

        // Single-nibble instance
        run_op1("n1_f_1", 4'hF, 4'h1, 1'b0, 5'h10);
        run_op1("n1_7_8_c1", 4'h7, 4'h8, 1'b1, 5'h10);
        run_op1("n1_3_4", 4'h3, 4'h4, 1'b0, 5'h07);
        run_op1("n1_f_f_c1", 4'hF, 4'hF, 1'b1, 5'h1F);
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            run_op1("n1_rand", ra[3:0], rb[3:0], rc, 5'(ra) + 5'(rb) + 5'(rc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
